// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - Decode->Execute pipeline register with stall, flush, valid and illegal-op squash
// Optional macro ID_EX_BUBBLE_CNT_EN enables the flush (bubble) counter on BubbleCntE.
module id_ex_pipeline_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [3:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [3:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             IllegalOpE,
    output logic [CNT_W-1:0] BubbleCntE
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [3:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal_op;
    } stage_t;

    stage_t stage_q, stage_d, load_v;
    logic   alu_legal;

    always_comb begin
        case (ALUControlD)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1100: alu_legal = 1'b1;
            default:          alu_legal = 1'b0;
        endcase
    end

    // An unsupported ALU op still occupies the slot (valid) but may not
    // change architectural state, so all side-effect enables are squashed.
    always_comb begin
        load_v             = '0;
        load_v.valid       = 1'b1;
        load_v.reg_write   = RegWriteD & alu_legal;
        load_v.result_src  = ResultSrcD;
        load_v.mem_write   = MemWriteD & alu_legal;
        load_v.jump        = JumpD & alu_legal;
        load_v.branch      = BranchD & alu_legal;
        load_v.alu_src     = ALUSrcD;
        load_v.alu_control = ALUControlD;
        load_v.rd1         = RD1D;
        load_v.rd2         = RD2D;
        load_v.pc          = PCD;
        load_v.pc_plus4    = PCPlus4D;
        load_v.imm_ext     = ImmExtD;
        load_v.rs1         = Rs1D;
        load_v.rs2         = Rs2D;
        load_v.rd          = RdD;
        load_v.illegal_op  = ~alu_legal;
    end

    always_comb begin
        stage_d = stage_q;
        if (FlushE) begin
            stage_d = '0;
        end else if (!StallE) begin
            stage_d = ValidD ? load_v : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ValidE      = stage_q.valid;
    assign RegWriteE   = stage_q.reg_write;
    assign ResultSrcE  = stage_q.result_src;
    assign MemWriteE   = stage_q.mem_write;
    assign JumpE       = stage_q.jump;
    assign BranchE     = stage_q.branch;
    assign ALUSrcE     = stage_q.alu_src;
    assign ALUControlE = stage_q.alu_control;
    assign RD1E        = stage_q.rd1;
    assign RD2E        = stage_q.rd2;
    assign PCE         = stage_q.pc;
    assign PCPlus4E    = stage_q.pc_plus4;
    assign ImmExtE     = stage_q.imm_ext;
    assign Rs1E        = stage_q.rs1;
    assign Rs2E        = stage_q.rs2;
    assign RdE         = stage_q.rd;
    assign IllegalOpE  = stage_q.illegal_op;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counts every flush edge, stalled or not; wraps naturally.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
`else
    assign BubbleCntE = '0;
`endif

endmodule
